fifo_read_stream: RTL and testbench

FIFO_READ_STREAM -- requirements
Module: fifo_read_stream

---
 rtl/fifo_read_stream_if.sv | 37 +++
 rtl/fifo_read_stream.sv | 107 ++++++++++
 tb/tb_fifo_read_stream.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_stream_if.sv
// Handshake bundle between a registered-read FIFO port, the stream adapter and its downstream consumer.
// The master side is the adapter; the slave side is the surrounding FIFO and sink.
interface fifo_read_stream_if #(
    parameter int BITS = 32,
    parameter int CNTW = 32
);
    logic            p_read_empty;
    logic            p_read_en;
    logic [BITS-1:0] p_read_data;
    logic            flush;
    logic            m_valid;
    logic            m_ready;
    logic [BITS-1:0] m_data;
    logic [CNTW-1:0] word_count;

    modport master (
        input  p_read_empty,
        output p_read_en,
        input  p_read_data,
        input  flush,
        output m_valid,
        input  m_ready,
        output m_data,
        output word_count
    );

    modport slave (
        output p_read_empty,
        input  p_read_en,
        output p_read_data,
        output flush,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  word_count
    );
endinterface

// File: rtl/fifo_read_stream.sv
// Turns a FIFO registered-read port into a valid/ready stream through a 2-entry in-order buffer.
// m_valid and m_data come straight from registers; only p_read_en is combinational.
module fifo_read_stream #(
    parameter int BITS = 32,
    parameter int CNTW = 32
) (
    input  logic                 read_clk,
    input  logic                 read_rst,
    fifo_read_stream_if.master   bus
);

    logic [1:0]      count_r;
    logic            inflight_r;
    logic            m_valid_r;
    logic [BITS-1:0] head_r;
    logic [BITS-1:0] tail_r;
    logic [CNTW-1:0] word_count_r;

    logic            pop_s;
    logic            rd_en_s;
    logic [1:0]      occ_s;
    logic [1:0]      kept_s;
    logic [1:0]      count_n_s;
    logic [BITS-1:0] head_n_s;
    logic [BITS-1:0] tail_n_s;

    // occ never exceeds 2: a read is only issued when a slot is free at capture time
    assign pop_s = m_valid_r && bus.m_ready;
    assign occ_s = count_r + {1'b0, inflight_r};

    // Read request: a slot must be free when the word lands, counting a same-cycle pop
    always_comb begin
        rd_en_s = 1'b0;
        if (!bus.p_read_empty && !bus.flush && !read_rst) begin
            if (occ_s < 2'd2) begin
                rd_en_s = 1'b1;
            end else if ((occ_s == 2'd2) && pop_s) begin
                rd_en_s = 1'b1;
            end else begin
                rd_en_s = 1'b0;
            end
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Buffer next state: pop shifts tail to head, then the arriving word fills the first free slot
    always_comb begin
        kept_s    = count_r - {1'b0, pop_s};
        count_n_s = kept_s;
        head_n_s  = head_r;
        tail_n_s  = tail_r;
        if (bus.flush) begin
            count_n_s = 2'd0;
        end else begin
            if (pop_s && (count_r == 2'd2)) begin
                head_n_s = tail_r;
            end else begin
                head_n_s = head_r;
            end
            if (inflight_r) begin
                if (kept_s == 2'd0) begin
                    head_n_s = bus.p_read_data;
                end else begin
                    tail_n_s = bus.p_read_data;
                end
                count_n_s = kept_s + 2'd1;
            end else begin
                count_n_s = kept_s;
            end
        end
    end

    // Buffer, in-flight tracking and output-valid registers
    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            count_r    <= 2'd0;
            inflight_r <= 1'b0;
            m_valid_r  <= 1'b0;
            head_r     <= {BITS{1'b0}};
            tail_r     <= {BITS{1'b0}};
        end else begin
            count_r    <= count_n_s;
            inflight_r <= rd_en_s;
            m_valid_r  <= (count_n_s != 2'd0);
            head_r     <= head_n_s;
            tail_r     <= tail_n_s;
        end
    end

    // Handshake counter; a pop in a flush cycle still completes and is counted
    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            word_count_r <= {CNTW{1'b0}};
        end else if (pop_s) begin
            word_count_r <= word_count_r + CNTW'(1);
        end else begin
            word_count_r <= word_count_r;
        end
    end

    assign bus.p_read_en  = rd_en_s;
    assign bus.m_valid    = m_valid_r;
    assign bus.m_data     = head_r;
    assign bus.word_count = word_count_r;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Scoreboard bench for fifo_read_stream: a FIFO model feeds the DUT, words read are queued as expected output.
// A second instance with a 4-bit counter shares the inputs to exercise counter wrap.
`timescale 1ns/1ps
module tb_fifo_read_stream;

    logic read_clk = 1'b0;
    logic read_rst;

    fifo_read_stream_if #(.BITS(32), .CNTW(32)) bus ();
    fifo_read_stream_if #(.BITS(32), .CNTW(4))  bus4 ();

    fifo_read_stream #(.BITS(32), .CNTW(32)) dut (
        .read_clk (read_clk),
        .read_rst (read_rst),
        .bus      (bus)
    );

    fifo_read_stream #(.BITS(32), .CNTW(4)) dut4 (
        .read_clk (read_clk),
        .read_rst (read_rst),
        .bus      (bus4)
    );

    assign bus4.p_read_empty = bus.p_read_empty;
    assign bus4.p_read_data  = bus.p_read_data;
    assign bus4.flush        = bus.flush;
    assign bus4.m_ready      = bus.m_ready;

    always #5 read_clk = ~read_clk;

    logic [31:0] src_q[$];
    logic [31:0] sb_q[$];
    bit          infl;
    bit          gate;
    int unsigned wc;
    int          errors;
    int          checks;
    int          cyc;
    int          rd_cnt;
    int          pop_cnt;
    int          first_rd;
    int          first_vld;
    int          last_pop;
    bit          prev_hold;
    logic [31:0] prev_data;
    bit          watch_flush;
    logic [31:0] flush_next;
    int unsigned wc_before;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic apply(input bit g, input bit rdy, input bit fl);
        gate             = g;
        bus.m_ready      = rdy;
        bus.flush        = fl;
        bus.p_read_empty = (src_q.size() == 0) || g;
    endtask

    task automatic set_reset(input bit on);
        read_rst = on;
        if (on) begin
            sb_q.delete();
            infl      = 1'b0;
            wc        = 0;
            prev_hold = 1'b0;
        end
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(base + 32'(i));
        bus.p_read_empty = (src_q.size() == 0) || gate;
    endtask

    task automatic tick();
        bit          ev;
        bit          pop;
        bit          er;
        int          occ;
        logic [31:0] w;
        w   = $urandom();
        er  = 1'b0;
        @(negedge read_clk);
        cyc++;
        occ = sb_q.size();
        if (read_rst) begin
            check_eq("rst_p_read_en", bus.p_read_en, 1'b0);
            check_eq("rst_m_valid", bus.m_valid, 1'b0);
            check_eq("rst_word_count", bus.word_count, 64'd0);
            check_eq("rst_m_data", bus.m_data, 64'd0);
        end else begin
            ev = ((occ - int'(infl)) != 0);
            check_eq("m_valid", bus.m_valid, ev);
            if (ev) check_eq("m_data", bus.m_data, sb_q[0]);
            if (prev_hold) check_eq("m_data_hold", bus.m_data, prev_data);
            pop = ev && bus.m_ready;
            er  = !bus.p_read_empty && !bus.flush && ((occ < 2) || ((occ == 2) && pop));
            check_eq("p_read_en", bus.p_read_en, er);
            check_eq("rd_while_empty", bus.p_read_en & bus.p_read_empty, 1'b0);
            check_eq("word_count", bus.word_count, wc);
            check_eq("word_count4", bus4.word_count, wc % 16);
            if (bus.p_read_en) rd_cnt++;
            if (er && first_rd < 0) first_rd = cyc;
            if (ev && first_vld < 0) first_vld = cyc;
            prev_hold = ev && !bus.m_ready && !bus.flush;
            prev_data = bus.m_data;
            if (pop) begin
                if (watch_flush) begin
                    check_eq("post_flush_word", bus.m_data, flush_next);
                    watch_flush = 1'b0;
                end
                void'(sb_q.pop_front());
                wc++;
                pop_cnt++;
                last_pop = cyc;
            end
        end
        @(posedge read_clk);
        if (!read_rst) begin
            if (bus.flush) begin
                sb_q.delete();
                infl = 1'b0;
            end else begin
                infl = er;
                if (er) begin
                    w = src_q.pop_front();
                    sb_q.push_back(w);
                end
            end
        end
        #1;
        bus.p_read_data  = w;
        bus.p_read_empty = (src_q.size() == 0) || gate;
    endtask

    task automatic drain(input int budget);
        apply(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < budget; i++) begin
            if (src_q.size() == 0 && sb_q.size() == 0) break;
            tick();
        end
        check_eq("drain_done", 64'(sb_q.size() + src_q.size()), 64'd0);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; wc = 0; infl = 1'b0; gate = 1'b0;
        prev_hold = 1'b0; watch_flush = 1'b0; rd_cnt = 0; pop_cnt = 0;
        bus.p_read_data = 32'h0;
        set_reset(1'b1);
        load(32'h1, 16);
        apply(1'b0, 1'b1, 1'b0);

        // reset with a non-empty FIFO
        for (int i = 0; i < 4; i++) tick();
        first_rd = -1; first_vld = -1; pop_cnt = 0; last_pop = 0;
        set_reset(1'b0);

        // streaming 0x1..0x10
        for (int i = 0; i < 40 && pop_cnt < 16; i++) tick();
        check_eq("stream_pops", 64'(pop_cnt), 64'd16);
        check_eq("first_latency", 64'(first_vld - first_rd), 64'd2);
        check_eq("stream_back_to_back", 64'(last_pop - first_vld), 64'd15);
        check_eq("stream_word_count", bus.word_count, 64'd16);

        // backpressure
        load(32'h20, 8);
        apply(1'b0, 1'b0, 1'b0);
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("backpressure_reads", 64'(rd_cnt), 64'd2);
        drain(40);

        // empty toggling every cycle, random ready
        load(32'h40, 32);
        for (int i = 0; i < 120; i++) begin
            apply(cyc[0], 1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
        drain(80);

        // flush while streaming
        load(32'h60, 16);
        apply(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        flush_next = src_q[0];
        apply(1'b0, 1'b1, 1'b1);
        tick();
        check_eq("flush_valid", bus.m_valid, 1'b0);
        watch_flush = 1'b1;
        drain(40);
        check_eq("flush_next_seen", 64'(watch_flush), 64'd0);

        // flush with a full buffer and a pop in the same cycle
        load(32'h70, 8);
        apply(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        wc_before = wc;
        apply(1'b0, 1'b1, 1'b1);
        tick();
        check_eq("flush_full_valid", bus.m_valid, 1'b0);
        check_eq("flush_pop_counted", bus.word_count, 64'(wc_before + 1));
        drain(40);

        // reset mid-transfer, then 17 pops for the 4-bit counter wrap
        load(32'h80, 4);
        apply(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        set_reset(1'b1);
        #1;
        check_eq("midrst_valid", bus.m_valid, 1'b0);
        tick();
        tick();
        src_q.delete();
        pop_cnt = 0;
        set_reset(1'b0);
        load(32'h90, 17);
        apply(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 60 && pop_cnt < 17; i++) tick();
        check_eq("wrap_pops", 64'(pop_cnt), 64'd17);
        check_eq("wrap_count4", bus4.word_count, 64'd1);
        check_eq("wrap_count32", bus.word_count, 64'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
